// File: rtl/jedro_1_test_monitor_if.sv
// Expected-table lookup and regfile read port between the test monitor
// (master) and the bench / self-test harness (slave).
interface jedro_1_test_monitor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IW         = 2
);
  logic [IW-1:0]         chk_idx_o;
  logic [4:0]            chk_reg_i;
  logic [DATA_WIDTH-1:0] chk_exp_i;
  logic [4:0]            rf_addr_o;
  logic [DATA_WIDTH-1:0] rf_data_i;

  modport master (
    output chk_idx_o, rf_addr_o,
    input  chk_reg_i, chk_exp_i, rf_data_i
  );

  modport slave (
    input  chk_idx_o, rf_addr_o,
    output chk_reg_i, chk_exp_i, rf_data_i
  );
endinterface

// File: rtl/jedro_1_test_monitor.sv
// Test-completion monitor for jedro_1: run until halt/timeout, drain, then check registers.
// Optional first-mismatch capture ports enabled by JEDRO_1_TEST_MONITOR_CAPTURE_EN.
//
// state     | meaning
// S_IDLE    | out of reset, start run on next edge
// S_RUN     | counting core cycles, waiting for halt or timeout
// S_DRAIN   | letting the pipeline settle before reading registers
// S_CHK_ADDR| register regfile address for current table entry
// S_CHK_CMP | compare regfile data against expected value
// S_DONE    | result held until reset
module jedro_1_test_monitor #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHECKS   = 4,
  parameter int MAX_CYCLES   = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16,
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 halt_i,
  jedro_1_test_monitor_if.master bus,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] fail_cnt_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o
`ifdef JEDRO_1_TEST_MONITOR_CAPTURE_EN
  ,
  output logic [IW-1:0]         first_fail_idx_o,
  output logic [DATA_WIDTH-1:0] first_fail_got_o,
  output logic [DATA_WIDTH-1:0] first_fail_exp_o
`endif
);

  localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // A zero-cycle drain still spends one cycle in S_DRAIN.
  localparam logic [DRW-1:0] DRAIN_LOAD = DRW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHECKS - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_CHK_ADDR, S_CHK_CMP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] fail_q, fail_d;
  logic                 to_q, to_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4:0]           addr_q, addr_d;
  logic [DRW-1:0]       drn_q, drn_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 mismatch;

  assign mismatch = (bus.rf_data_i != bus.chk_exp_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      fail_q  <= '0;
      to_q    <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    fail_d  = fail_q;
    to_d    = to_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (halt_i) begin
          // halt beats a simultaneous timeout and freezes the counter
          state_d = S_DRAIN;
          drn_d   = DRAIN_LOAD;
        end else begin
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
          if (cyc_q >= CYC_LAST) begin
            to_d    = 1'b1;
            state_d = S_DRAIN;
            drn_d   = DRAIN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) state_d = S_CHK_ADDR;
        else             drn_d   = drn_q - 1'b1;
      end
      S_CHK_ADDR: begin
        addr_d  = bus.chk_reg_i;
        state_d = S_CHK_CMP;
      end
      S_CHK_CMP: begin
        if (mismatch && (fail_q != '1)) fail_d = fail_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
          done_d  = 1'b1;
          pass_d  = (fail_d == '0) && !to_q;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CHK_ADDR;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.chk_idx_o = idx_q;
  assign bus.rf_addr_o = addr_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = to_q;
  assign fail_cnt_o    = fail_q;
  assign cycle_cnt_o   = cyc_q;

`ifdef JEDRO_1_TEST_MONITOR_CAPTURE_EN
  logic                  cap_q;
  logic [IW-1:0]         ff_idx_q;
  logic [DATA_WIDTH-1:0] ff_got_q, ff_exp_q;

  // cap_q marks that the first mismatch has already been latched
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cap_q    <= 1'b0;
      ff_idx_q <= '0;
      ff_got_q <= '0;
      ff_exp_q <= '0;
    end else if (state_q == S_CHK_CMP && mismatch) begin
      if (!cap_q) begin
        cap_q    <= 1'b1;
        ff_idx_q <= idx_q;
        ff_got_q <= bus.rf_data_i;
        ff_exp_q <= bus.chk_exp_i;
      end
`ifndef SYNTHESIS
      $display("jedro_1_test_monitor: check %0d x%0d got %0d exp %0d",
               idx_q, addr_q, $signed(bus.rf_data_i), $signed(bus.chk_exp_i));
`endif
    end
  end

  assign first_fail_idx_o = ff_idx_q;
  assign first_fail_got_o = ff_got_q;
  assign first_fail_exp_o = ff_exp_q;
`endif

endmodule
